// File: rtl/nanorv32_retire_trace_buffer_if.sv
// Retire, data-bus completion and trace stream signals of the nanorv32 trace buffer.
// The master side is the core and the trace consumer; the slave side is the buffer.
interface nanorv32_retire_trace_buffer_if #(
    parameter int DATA_W = 32
);
    logic              ret_valid;
    logic [DATA_W-1:0] ret_pc;
    logic [DATA_W-1:0] ret_instr;
    logic              ret_rd_wen;
    logic [4:0]        ret_rd_idx;
    logic [DATA_W-1:0] ret_rd_val;
    logic              ret_is_mem;
    logic              ret_is_store;
    logic [DATA_W-1:0] ret_mem_addr;

    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mem_wdata;

    logic              trace_valid;
    logic              trace_ready;
    logic [DATA_W-1:0] trace_pc;
    logic [DATA_W-1:0] trace_instr;
    logic [DATA_W-1:0] trace_rd_val;
    logic [DATA_W-1:0] trace_mem_addr;
    logic [4:0]        trace_rd_idx;
    logic              trace_rd_wen;
    logic              trace_is_mem;
    logic              trace_is_store;
    logic              trace_mem_err;

    modport master (
        output ret_valid, ret_pc, ret_instr, ret_rd_wen, ret_rd_idx, ret_rd_val,
               ret_is_mem, ret_is_store, ret_mem_addr,
               mem_done, mem_rdata, mem_wdata, trace_ready,
        input  trace_valid, trace_pc, trace_instr, trace_rd_val, trace_mem_addr,
               trace_rd_idx, trace_rd_wen, trace_is_mem, trace_is_store, trace_mem_err
    );

    modport slave (
        input  ret_valid, ret_pc, ret_instr, ret_rd_wen, ret_rd_idx, ret_rd_val,
               ret_is_mem, ret_is_store, ret_mem_addr,
               mem_done, mem_rdata, mem_wdata, trace_ready,
        output trace_valid, trace_pc, trace_instr, trace_rd_val, trace_mem_addr,
               trace_rd_idx, trace_rd_wen, trace_is_mem, trace_is_store, trace_mem_err
    );
endinterface

// File: rtl/nanorv32_retire_trace_buffer.sv
// In-order retire trace buffer; load/store records wait for their data-bus completion.
// Latency: retire in N -> trace_valid in N+1; completion in M -> pending head valid in M+1.
// Backpressure: valid/ready on the trace side; when full without a pop, retires are dropped and counted.
module nanorv32_retire_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    nanorv32_retire_trace_buffer_if.slave bus,
    output logic [PTR_W:0]              trace_count,
    output logic                        overflow,
    output logic                        proto_err,
    output logic [CNT_W-1:0]            drop_cnt
);
    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] rd_val;
        logic [DATA_W-1:0] mem_addr;
        logic [4:0]        rd_idx;
        logic              rd_wen;
        logic              is_mem;
        logic              is_store;
        logic              mem_err;
        logic              pend;
    } rec_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    rec_t             slots [DEPTH];
    rec_t             head;
    rec_t             new_rec;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] pend_ptr;
    logic [PTR_W:0]   count;
    logic             pend_active;

    logic full;
    logic pop;
    logic push_ok;
    logic drop;
    logic done_hit;
    logic force_rel;

    assign head      = slots[rd_ptr];
    assign full      = (count == FULL_CNT);
    assign pop       = bus.trace_valid & bus.trace_ready;
    assign push_ok   = bus.ret_valid & (~full | pop);
    assign drop      = bus.ret_valid & full & ~pop;
    assign done_hit  = bus.mem_done & pend_active;
    // A dropped retire never touches pending tracking, so only accepted memory retires force-release.
    assign force_rel = push_ok & bus.ret_is_mem & pend_active & ~bus.mem_done;

    always_comb begin
        new_rec          = '0;
        new_rec.pc       = bus.ret_pc;
        new_rec.instr    = bus.ret_instr;
        new_rec.rd_val   = bus.ret_rd_val;
        new_rec.mem_addr = bus.ret_mem_addr;
        new_rec.rd_idx   = bus.ret_rd_idx;
        new_rec.rd_wen   = bus.ret_rd_wen;
        new_rec.is_mem   = bus.ret_is_mem;
        new_rec.is_store = bus.ret_is_mem & bus.ret_is_store;
        new_rec.pend     = bus.ret_is_mem;
    end

    assign bus.trace_valid    = (count != '0) && !head.pend;
    assign bus.trace_pc       = head.pc;
    assign bus.trace_instr    = head.instr;
    assign bus.trace_rd_val   = head.rd_val;
    assign bus.trace_mem_addr = head.mem_addr;
    assign bus.trace_rd_idx   = head.rd_idx;
    assign bus.trace_rd_wen   = head.rd_wen;
    assign bus.trace_is_mem   = head.is_mem;
    assign bus.trace_is_store = head.is_store;
    assign bus.trace_mem_err  = head.mem_err;
    assign trace_count        = count;

    // The pending slot is never the one being written: it cannot be popped, so a push into a full
    // buffer always lands on the non-pending head slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (!clr) begin
            if (done_hit) begin
                slots[pend_ptr].pend <= 1'b0;
                if (slots[pend_ptr].is_store) begin
                    slots[pend_ptr].rd_val <= bus.mem_wdata;
                    slots[pend_ptr].rd_wen <= 1'b0;
                end else begin
                    slots[pend_ptr].rd_val <= bus.mem_rdata;
                    slots[pend_ptr].rd_wen <= (slots[pend_ptr].rd_idx != 5'd0);
                end
            end else if (force_rel) begin
                slots[pend_ptr].pend    <= 1'b0;
                slots[pend_ptr].mem_err <= 1'b1;
            end
            if (push_ok) begin
                slots[wr_ptr] <= new_rec;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pend_ptr    <= '0;
            count       <= '0;
            pend_active <= 1'b0;
            overflow    <= 1'b0;
            proto_err   <= 1'b0;
            drop_cnt    <= '0;
        end else if (clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pend_ptr    <= '0;
            count       <= '0;
            pend_active <= 1'b0;
            overflow    <= 1'b0;
            proto_err   <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase

            if (push_ok && bus.ret_is_mem) begin
                pend_active <= 1'b1;
                pend_ptr    <= wr_ptr;
            end else if (done_hit) begin
                pend_active <= 1'b0;
            end

            if (force_rel) begin
                proto_err <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule
